hazard_stall_ctrl: RTL and testbench

//  Pipeline stall controller for the 5-stage MIPS core. Decides each cycle whether the

---
 rtl/mips_pkg.sv | 32 +++
 rtl/md_busy_counter.sv | 49 ++++
 rtl/hazard_stall_ctrl.sv | 73 +++++++
 tb/tb_hazard_stall_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared encodings for the 5-stage MIPS core's hazard logic.
//   - TUSE_*: cycles until the D-stage instruction needs an operand (3 = never).
//   - TNEW_*: cycles until a producer's result can be forwarded.
//   - MULT_LAT_DEF / DIV_LAT_DEF: default busy lengths of the MULT/DIV unit.
//   - REG_ZERO: the hard-wired zero register, which never carries a dependency.
package mips_pkg;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0    = 2'd0;
    localparam logic [1:0] TNEW_1    = 2'd1;
    localparam logic [1:0] TNEW_2    = 2'd2;
    localparam logic [1:0] TNEW_NONE = 2'd3;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source register in D conflicts with a producer when the producer writes
    // it and the value will not be forwardable by the time D consumes it.
    // TUSE_NONE is 3, which can never be below any real Tnew (max 2).
    function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] wa,  input logic [1:0] tnew);
        return (src == wa) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter
// Tracks how long the MULT/DIV unit stays busy after a start.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   md_start   in   1-cycle start pulse from the E stage
//   md_is_div  in   1 = DIV/DIVU, 0 = MULT/MULTU (only looked at with md_start)
//   md_busy    out  HI/LO not yet valid
module md_busy_counter
    import mips_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    logic [3:0] md_cnt_q;
    logic [3:0] md_cnt_d;

    // A start always reloads, even mid-count: the most recent operation wins.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = md_is_div ? DIV_CNT : MULT_CNT;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q <= 4'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    // Busy already in the start cycle so a dependent instruction in D is held.
    assign md_busy = md_start | (md_cnt_q != 4'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline stall controller: freezes PC and IF/ID and bubbles ID/EX whenever the
// D-stage instruction has a RAW dependency that forwarding cannot resolve in time
// (Tuse/Tnew model) or needs HI/LO while the MULT/DIV unit is busy.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   d_rs, d_rt             source registers of the D instruction
//   d_rs_tuse, d_rt_tuse   cycles until each source is needed (3 = unused)
//   d_uses_md              D instruction touches MULT/DIV or HI/LO
//   e_wa, e_tnew           destination / Tnew of the E instruction
//   m_wa, m_tnew           destination / Tnew of the M instruction
//   md_start, md_is_div    MULT/DIV start pulse and its kind
//   pc_en, fd_en           PC and IF/ID enables
//   de_clr                 ID/EX bubble insert
//   md_busy                MULT/DIV unit busy
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic       d_uses_md,
    input  logic [4:0] e_wa,
    input  logic [1:0] e_tnew,
    input  logic [4:0] m_wa,
    input  logic [1:0] m_tnew,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_clr,
    output logic       md_busy
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_counter (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy)
    );

    // $0 may appear as a destination of "no write"; it must never stall.
    assign stall_rs = (d_rs != REG_ZERO) &&
                      (raw_hit(d_rs, d_rs_tuse, e_wa, e_tnew) ||
                       raw_hit(d_rs, d_rs_tuse, m_wa, m_tnew));

    assign stall_rt = (d_rt != REG_ZERO) &&
                      (raw_hit(d_rt, d_rt_tuse, e_wa, e_tnew) ||
                       raw_hit(d_rt, d_rt_tuse, m_wa, m_tnew));

    assign stall_md = d_uses_md & md_busy;

    assign stall  = stall_rs | stall_rt | stall_md;
    assign pc_en  = ~stall;
    assign fd_en  = ~stall;
    assign de_clr = stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    typedef struct {
        logic       reset;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] rs_tuse;
        logic [1:0] rt_tuse;
        logic       uses_md;
        logic [4:0] e_wa;
        logic [1:0] e_tnew;
        logic [4:0] m_wa;
        logic [1:0] m_tnew;
        logic       md_start;
        logic       md_is_div;
    } vin_t;

    typedef struct {
        vin_t       v;
        logic [3:0] exp; // {pc_en, fd_en, de_clr, md_busy}
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_wa, m_wa;
    logic [1:0] d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
    logic       d_uses_md, md_start, md_is_div;
    logic       pc_en, fd_en, de_clr, md_busy;

    int total = 0;
    int bad   = 0;

    // Reference state: absolute cycle index at which the MULT/DIV unit is free.
    int cyc     = 0;
    int free_at = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_rs_tuse (d_rs_tuse),
        .d_rt_tuse (d_rt_tuse),
        .d_uses_md (d_uses_md),
        .e_wa      (e_wa),
        .e_tnew    (e_tnew),
        .m_wa      (m_wa),
        .m_tnew    (m_tnew),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .de_clr    (de_clr),
        .md_busy   (md_busy)
    );

    function automatic vin_t idle();
        vin_t v;
        v.reset = 1'b1; v.rs = 5'd0; v.rt = 5'd0; v.rs_tuse = 2'd3; v.rt_tuse = 2'd3;
        v.uses_md = 1'b0; v.e_wa = 5'd0; v.e_tnew = 2'd0; v.m_wa = 5'd0; v.m_tnew = 2'd0;
        v.md_start = 1'b0; v.md_is_div = 1'b0;
        return v;
    endfunction

    // Higher-level view: an operand is late if any in-flight producer of it
    // delivers after the consumer needs it.
    function automatic logic model_raw(input vin_t v);
        logic [4:0] srcs [2];
        logic [1:0] uses [2];
        logic [4:0] dsts [2];
        logic [1:0] news [2];
        logic       late;
        srcs[0] = v.rs; srcs[1] = v.rt; uses[0] = v.rs_tuse; uses[1] = v.rt_tuse;
        dsts[0] = v.e_wa; dsts[1] = v.m_wa; news[0] = v.e_tnew; news[1] = v.m_tnew;
        late = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < 2; p++)
                if (srcs[s] != 0 && srcs[s] == dsts[p] && int'(news[p]) > int'(uses[s]))
                    late = 1'b1;
        return late;
    endfunction

    task automatic drive(input vin_t v);
        reset = v.reset; d_rs = v.rs; d_rt = v.rt; d_rs_tuse = v.rs_tuse;
        d_rt_tuse = v.rt_tuse; d_uses_md = v.uses_md; e_wa = v.e_wa; e_tnew = v.e_tnew;
        m_wa = v.m_wa; m_tnew = v.m_tnew; md_start = v.md_start; md_is_div = v.md_is_div;
    endtask

    // One clock cycle: drive, compare at negedge against the model (and an
    // optional hand-derived constant), then advance the model at posedge.
    task automatic step(input vin_t v, input string name, input bit has_exp,
                        input logic [3:0] exp);
        logic       busy_m, stall_m;
        logic [3:0] got, mdl;
        drive(v);
        if (!v.reset) free_at = 0;
        @(negedge clk);
        busy_m  = v.md_start | (cyc < free_at);
        stall_m = model_raw(v) | (v.uses_md & busy_m);
        mdl = {~stall_m, ~stall_m, stall_m, busy_m};
        got = {pc_en, fd_en, de_clr, md_busy};
        total++;
        if (got !== mdl) begin
            bad++;
            $display("FAIL %s cyc=%0d model: got=%b want=%b", name, cyc, got, mdl);
        end else begin
            $display("ok   %s cyc=%0d outs=%b", name, cyc, got);
        end
        if (has_exp) begin
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d const: got=%b want=%b", name, cyc, got, exp);
            end
        end
        @(posedge clk);
        if (v.reset && v.md_start) free_at = cyc + (v.md_is_div ? DIV_LAT : MULT_LAT) + 1;
        cyc++;
        #1;
    endtask

    vec_t table_v [10];

    initial begin
        vin_t v;
        int   t0;

        for (int i = 0; i < 10; i++) begin
            table_v[i].v = idle();
            table_v[i].exp = 4'b1100;
        end
        table_v[0].v.rs = 5;  table_v[0].v.rs_tuse = 0; table_v[0].v.e_wa = 5; table_v[0].v.e_tnew = 2; table_v[0].exp = 4'b0010;
        table_v[1].v.rs = 5;  table_v[1].v.rs_tuse = 1; table_v[1].v.e_wa = 5; table_v[1].v.e_tnew = 2; table_v[1].exp = 4'b0010;
        table_v[2].v.rs = 5;  table_v[2].v.rs_tuse = 2; table_v[2].v.e_wa = 5; table_v[2].v.e_tnew = 2;
        table_v[3].v.rs = 5;  table_v[3].v.rs_tuse = 3; table_v[3].v.e_wa = 5; table_v[3].v.e_tnew = 2;
        table_v[4].v.rt = 7;  table_v[4].v.rt_tuse = 0; table_v[4].v.m_wa = 7; table_v[4].v.m_tnew = 1; table_v[4].exp = 4'b0010;
        table_v[5].v.rt = 7;  table_v[5].v.rt_tuse = 1; table_v[5].v.m_wa = 7; table_v[5].v.m_tnew = 1;
        table_v[6].v.rs = 0;  table_v[6].v.rs_tuse = 0; table_v[6].v.e_wa = 0; table_v[6].v.e_tnew = 2;
        table_v[7].v.rt = 9;  table_v[7].v.rt_tuse = 1; table_v[7].v.m_wa = 9; table_v[7].v.m_tnew = 2; table_v[7].exp = 4'b0010;
        table_v[8].v.rs = 3;  table_v[8].v.rt = 4; table_v[8].v.rs_tuse = 0; table_v[8].v.rt_tuse = 0; table_v[8].v.e_wa = 6; table_v[8].v.e_tnew = 2;
        table_v[9].v.uses_md = 1;

        // Reset state
        v = idle(); v.reset = 1'b0;
        drive(v);
        #2;
        step(v, "reset", 1, 4'b1100);
        step(v, "reset_hold", 1, 4'b1100);

        for (int i = 0; i < 10; i++)
            step(table_v[i].v, $sformatf("table%0d", i), 1, table_v[i].exp);

        // 1: reset while the counter holds 7
        v = idle(); v.md_start = 1; v.md_is_div = 1;
        step(v, "rst_mid_start", 1, 4'b1101);
        v = idle();
        for (int i = 0; i < 3; i++) step(v, "rst_mid_count", 1, 4'b1101);
        v = idle(); v.reset = 0;
        step(v, "rst_mid_assert", 1, 4'b1100);
        v = idle(); v.uses_md = 1;
        step(v, "rst_mid_release", 1, 4'b1100);

        // 2: lw in E then M, beq in D
        v = idle(); v.rs = 5; v.rs_tuse = 0; v.e_wa = 5; v.e_tnew = 2;
        step(v, "lw_e", 1, 4'b0010);
        v.e_wa = 0; v.e_tnew = 0; v.m_wa = 5; v.m_tnew = 1;
        step(v, "lw_m", 1, 4'b0010);
        v.m_wa = 0; v.m_tnew = 0;
        step(v, "lw_w", 1, 4'b1100);

        // 3: $0 never stalls
        v = idle(); v.rs = 0; v.rs_tuse = 0; v.e_wa = 0; v.e_tnew = 2;
        step(v, "zero_reg", 1, 4'b1100);

        // 4: DIV then MFLO waits DIV_LAT cycles
        v = idle(); v.md_start = 1; v.md_is_div = 1;
        step(v, "div_start", 1, 4'b1101);
        v = idle(); v.uses_md = 1;
        for (int i = 1; i <= DIV_LAT; i++) step(v, $sformatf("mflo_wait%0d", i), 1, 4'b0011);
        step(v, "mflo_go", 1, 4'b1100);

        // 5: MULT then independent ADDU
        v = idle(); v.md_start = 1;
        step(v, "mult_start", 1, 4'b1101);
        v = idle(); v.rs = 2; v.rs_tuse = 1;
        for (int i = 1; i <= MULT_LAT; i++) step(v, $sformatf("addu_busy%0d", i), 1, 4'b1101);
        step(v, "addu_free", 1, 4'b1100);

        // 6: RAW and MD stalls overlapping, RAW clears first
        v = idle(); v.md_start = 1; v.uses_md = 1; v.rs = 8; v.rs_tuse = 0; v.e_wa = 8; v.e_tnew = 2;
        step(v, "ovl_start", 1, 4'b0011);
        v.md_start = 0;
        for (int i = 1; i <= 3; i++) step(v, $sformatf("ovl_both%0d", i), 1, 4'b0011);
        v.e_wa = 0;
        for (int i = 4; i <= MULT_LAT; i++) step(v, $sformatf("ovl_md%0d", i), 1, 4'b0011);
        step(v, "ovl_go", 1, 4'b1100);

        // md_start while busy reloads (latest wins)
        v = idle(); v.md_start = 1; v.md_is_div = 1;
        step(v, "reload_div", 0, 4'b0);
        v = idle(); step(v, "reload_gap", 0, 4'b0);
        v.md_start = 1; v.md_is_div = 0;
        step(v, "reload_mult", 0, 4'b0);
        v = idle(); v.uses_md = 1;
        for (int i = 0; i < MULT_LAT + 2; i++) step(v, "reload_after", 0, 4'b0);

        // Random traffic against the model
        t0 = cyc;
        while (cyc - t0 < 400) begin
            v.reset     = ($urandom_range(0, 49) != 0);
            v.rs        = 5'($urandom_range(0, 3));
            v.rt        = 5'($urandom_range(0, 3));
            v.rs_tuse   = 2'($urandom_range(0, 3));
            v.rt_tuse   = 2'($urandom_range(0, 3));
            v.uses_md   = 1'($urandom_range(0, 1));
            v.e_wa      = 5'($urandom_range(0, 3));
            v.e_tnew    = 2'($urandom_range(0, 2));
            v.m_wa      = 5'($urandom_range(0, 3));
            v.m_tnew    = 2'($urandom_range(0, 2));
            v.md_start  = ($urandom_range(0, 7) == 0);
            v.md_is_div = 1'($urandom_range(0, 1));
            step(v, "rand", 0, 4'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
